// File: rtl/cle_serial_collector.sv
// Collects SDRD bits from qualified $1xxx window reads into words, LSB first,
// and queues completed words in a small FIFO with a valid/ready output.
module cle_serial_collector #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        bus_stb,
  input  logic                        SSER,
  input  logic                        BA13,
  input  logic                        BA12,
  input  logic                        BR_W,
  input  logic                        SDRD,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(DATA_W)-1:0]   bit_cnt,
  output logic                        frame_err,
  output logic                        overflow,
  input  logic                        clr_ovf
);

  localparam int unsigned CNT_W  = $clog2(DATA_W);
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = AW + 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0]  LastBit  = CNT_W'(DATA_W - 1);
  localparam logic [IDLE_W-1:0] IdleLast = IDLE_W'(TIMEOUT_CYCLES - 1);

  // Bus decode
  logic win, rd_q, wr_q;

  // Assembly state
  logic [DATA_W-2:0] sh_q, sh_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              frame_err_q, frame_err_d;
  logic [DATA_W-1:0] shifted;
  logic              push_req;

  // FIFO state
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              overflow_q, overflow_d;
  logic              empty, full, pop, do_push, drop;

  assign win  = ~SSER & ~BA13 & BA12;
  assign rd_q = bus_stb & win & BR_W;
  assign wr_q = bus_stb & win & ~BR_W;

  // Incoming bit lands in the MSB; the completed word is exactly this value.
  assign shifted = {SDRD, sh_q};

  always_comb begin
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    idle_d      = idle_q;
    frame_err_d = 1'b0;
    push_req    = 1'b0;
    if (rd_q) begin
      sh_d   = shifted[DATA_W-1:1];
      idle_d = '0;
      if (bit_cnt_q == LastBit) begin
        push_req  = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end else if (wr_q) begin
      sh_d      = '0;
      bit_cnt_d = '0;
      idle_d    = '0;
    end else if (bit_cnt_q == '0) begin
      idle_d = '0;
    end else if (idle_q == IdleLast) begin
      sh_d        = '0;
      bit_cnt_d   = '0;
      idle_d      = '0;
      frame_err_d = 1'b1;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = ~empty & out_ready;
  assign do_push = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  always_comb begin
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(do_push);
    out_data_d = out_data_q;
    // Head register tracks the entry at the post-update read pointer; when that
    // slot is the one being written this cycle, forward the pushed word.
    if (wr_ptr_d != rd_ptr_d) begin
      if (do_push && (rd_ptr_d == wr_ptr_q)) begin
        out_data_d = shifted;
      end else begin
        out_data_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      idle_q      <= '0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_q      <= idle_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shifted;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = ~empty;
  assign bit_cnt   = bit_cnt_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cle_serial_collector.sv
// Directed bench for cle_serial_collector: vector table plus multi-cycle sequences.
module tb_cle_serial_collector;

  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bus_stb = 1'b0, SSER = 1'b1, BA13 = 1'b0, BA12 = 1'b0, BR_W = 1'b1, SDRD = 1'b1;
  logic          out_ready = 1'b0, clr_ovf = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid, frame_err, overflow;
  logic [2:0]    bit_cnt;

  int total = 0;
  int bad   = 0;

  cle_serial_collector #(
    .DATA_W        (DW),
    .FIFO_DEPTH    (2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus_stb  (bus_stb),
    .SSER     (SSER),
    .BA13     (BA13),
    .BA12     (BA12),
    .BR_W     (BR_W),
    .SDRD     (SDRD),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bit_cnt  (bit_cnt),
    .frame_err(frame_err),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stb, sser, ba13, ba12, brw, sdrd, rdy, clr;
    logic       e_valid;
    logic [7:0] e_data;
    logic [2:0] e_cnt;
    logic       e_ovf, e_ferr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic stb, sser, ba13, ba12, brw, sdrd, rdy, clr,
                     input logic ev, input logic [7:0] ed, input logic [2:0] ec,
                     input logic eo, ef);
    vec_t v;
    v.stb = stb; v.sser = sser; v.ba13 = ba13; v.ba12 = ba12; v.brw = brw;
    v.sdrd = sdrd; v.rdy = rdy; v.clr = clr;
    v.e_valid = ev; v.e_data = ed; v.e_cnt = ec; v.e_ovf = eo; v.e_ferr = ef;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [7:0] ed,
                         input logic [2:0] ec, input logic eo, input logic ef);
    chk({tag, " valid"}, 32'(out_valid), 32'(ev));
    chk({tag, " data"}, 32'(out_data), 32'(ed));
    chk({tag, " bit_cnt"}, 32'(bit_cnt), 32'(ec));
    chk({tag, " overflow"}, 32'(overflow), 32'(eo));
    chk({tag, " frame_err"}, 32'(frame_err), 32'(ef));
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic step(input logic stb, sser, ba13, ba12, brw, sdrd, rdy, clr);
    bus_stb = stb; SSER = sser; BA13 = ba13; BA12 = ba12; BR_W = brw; SDRD = sdrd;
    out_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    #1;
    bus_stb = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic rd_bit(input logic b, input logic rdy, input logic clr);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, b, rdy, clr);
  endtask

  task automatic idle_cyc(input logic rdy);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, rdy, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) rd_bit(b[i], 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int early;
    // 8'hA5 LSB first, hold, then pop
    add(1,0,0,1,1,1,0,0, 0,8'h00,3'd1,0,0);
    add(1,0,0,1,1,0,0,0, 0,8'h00,3'd2,0,0);
    add(1,0,0,1,1,1,0,0, 0,8'h00,3'd3,0,0);
    add(1,0,0,1,1,0,0,0, 0,8'h00,3'd4,0,0);
    add(1,0,0,1,1,0,0,0, 0,8'h00,3'd5,0,0);
    add(1,0,0,1,1,1,0,0, 0,8'h00,3'd6,0,0);
    add(1,0,0,1,1,0,0,0, 0,8'h00,3'd7,0,0);
    add(1,0,0,1,1,1,0,0, 1,8'hA5,3'd0,0,0);
    add(0,1,0,0,1,0,1,0, 0,8'hA5,3'd0,0,0);
    // 4 bits, window write resync, then 8'hF0
    add(1,0,0,1,1,1,0,0, 0,8'hA5,3'd1,0,0);
    add(1,0,0,1,1,1,0,0, 0,8'hA5,3'd2,0,0);
    add(1,0,0,1,1,1,0,0, 0,8'hA5,3'd3,0,0);
    add(1,0,0,1,1,1,0,0, 0,8'hA5,3'd4,0,0);
    add(1,0,0,1,0,0,0,0, 0,8'hA5,3'd0,0,0);
    add(1,0,0,1,1,0,0,0, 0,8'hA5,3'd1,0,0);
    add(1,0,0,1,1,0,0,0, 0,8'hA5,3'd2,0,0);
    add(1,0,0,1,1,0,0,0, 0,8'hA5,3'd3,0,0);
    add(1,0,0,1,1,0,0,0, 0,8'hA5,3'd4,0,0);
    add(1,0,0,1,1,1,0,0, 0,8'hA5,3'd5,0,0);
    add(1,0,0,1,1,1,0,0, 0,8'hA5,3'd6,0,0);
    add(1,0,0,1,1,1,0,0, 0,8'hA5,3'd7,0,0);
    add(1,0,0,1,1,1,0,0, 1,8'hF0,3'd0,0,0);
    add(0,1,0,0,1,0,1,0, 0,8'hF0,3'd0,0,0);
    // decode rejection: none of these may move bit_cnt
    add(1,0,0,1,1,1,0,0, 0,8'hF0,3'd1,0,0);
    add(1,0,0,1,1,1,0,0, 0,8'hF0,3'd2,0,0);
    add(1,1,0,1,1,1,0,0, 0,8'hF0,3'd2,0,0);
    add(1,0,1,1,1,1,0,0, 0,8'hF0,3'd2,0,0);
    add(1,0,0,0,1,1,0,0, 0,8'hF0,3'd2,0,0);
    add(0,0,0,1,1,1,0,0, 0,8'hF0,3'd2,0,0);
    add(1,1,0,1,0,0,0,0, 0,8'hF0,3'd2,0,0);
    add(1,0,0,1,0,0,0,0, 0,8'hF0,3'd0,0,0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all("reset", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].stb, vecs[i].sser, vecs[i].ba13, vecs[i].ba12, vecs[i].brw,
           vecs[i].sdrd, vecs[i].rdy, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data, vecs[i].e_cnt,
              vecs[i].e_ovf, vecs[i].e_ferr);
    end

    // Overflow: third byte dropped, FIFO keeps 11,22
    send_byte(8'h11);
    chk_all("ovf b1", 1'b1, 8'h11, 3'd0, 1'b0, 1'b0);
    send_byte(8'h22);
    send_byte(8'h33);
    chk_all("ovf b3", 1'b1, 8'h11, 3'd0, 1'b1, 1'b0);
    idle_cyc(1'b1);
    chk_all("ovf pop1", 1'b1, 8'h22, 3'd0, 1'b1, 1'b0);
    idle_cyc(1'b1);
    chk_all("ovf pop2", 1'b0, 8'h22, 3'd0, 1'b1, 1'b0);
    idle_cyc(1'b1);
    chk_all("pop empty", 1'b0, 8'h22, 3'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Set wins over clear; then push+pop on a full FIFO
    send_byte(8'h11);
    send_byte(8'h22);
    for (int i = 0; i < 7; i++) rd_bit(1'(8'h55 >> i), 1'b0, 1'b0);
    rd_bit(1'b0, 1'b0, 1'b1);
    chk_all("set wins", 1'b1, 8'h11, 3'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("clr again", 32'(overflow), 32'd0);
    idle_cyc(1'b1);
    chk_all("pop 11", 1'b1, 8'h22, 3'd0, 1'b0, 1'b0);
    send_byte(8'h66);
    chk_all("refill", 1'b1, 8'h22, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) rd_bit(1'(8'h44 >> i), 1'b0, 1'b0);
    rd_bit(1'b0, 1'b1, 1'b0);
    chk_all("full push+pop", 1'b1, 8'h66, 3'd0, 1'b0, 1'b0);
    idle_cyc(1'b1);
    chk_all("order 44", 1'b1, 8'h44, 3'd0, 1'b0, 1'b0);
    idle_cyc(1'b1);
    chk_all("drained", 1'b0, 8'h44, 3'd0, 1'b0, 1'b0);

    // Timeout after 5 bits
    for (int i = 0; i < 5; i++) rd_bit(1'b1, 1'b0, 1'b0);
    chk("to cnt5", 32'(bit_cnt), 32'd5);
    early = 0;
    for (int k = 1; k < int'(TO); k++) begin
      idle_cyc(1'b0);
      if (frame_err !== 1'b0 || bit_cnt !== 3'd5) early++;
    end
    chk("to no early", 32'(early), 32'd0);
    idle_cyc(1'b0);
    chk("to ferr", 32'(frame_err), 32'd1);
    chk("to cnt0", 32'(bit_cnt), 32'd0);
    idle_cyc(1'b0);
    chk("to pulse end", 32'(frame_err), 32'd0);
    send_byte(8'h3C);
    chk_all("after to", 1'b1, 8'h3C, 3'd0, 1'b0, 1'b0);
    idle_cyc(1'b1);

    // Access on the expiry cycle wins
    for (int i = 0; i < 5; i++) rd_bit(1'b1, 1'b0, 1'b0);
    early = 0;
    for (int k = 1; k < int'(TO); k++) begin
      idle_cyc(1'b0);
      if (frame_err !== 1'b0) early++;
    end
    chk("exp no early", 32'(early), 32'd0);
    rd_bit(1'b1, 1'b0, 1'b0);
    chk("exp cnt6", 32'(bit_cnt), 32'd6);
    chk("exp ferr0", 32'(frame_err), 32'd0);
    idle_cyc(1'b0);
    chk("exp ferr0b", 32'(frame_err), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("exp resync", 32'(bit_cnt), 32'd0);

    // Reset mid-word with a full FIFO and sticky overflow
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    for (int i = 0; i < 6; i++) rd_bit(1'b1, 1'b0, 1'b0);
    chk_all("pre rst", 1'b1, 8'h66, 3'd6, 1'b1, 1'b0);
    rst = 1'b1;
    idle_cyc(1'b0);
    rst = 1'b0;
    chk_all("mid rst", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    send_byte(8'h5A);
    chk_all("post rst", 1'b1, 8'h5A, 3'd0, 1'b0, 1'b0);
    idle_cyc(1'b1);
    chk_all("post rst pop", 1'b0, 8'h5A, 3'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
